// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with two registered read ports
// and one write port. After reset, a clear sequencer writes zero into every
// entry. Until that sequence finishes, busy is high, external writes are
// ignored and both read ports return zero.
//
// Build option REGFILE_BYPASS_EN:
//   defined     - write-first. A read of the entry being written in the same
//                 cycle returns the new data.
//   not defined - read-first. A read of the entry being written in the same
//                 cycle returns the old contents.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zero entry r_clr_idx each cycle, busy=1, reads forced to 0
// ST_RUN   | normal read/write traffic, busy=0

module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_read1;
    logic [DATA_W-1:0] r_read2;

    logic              w_clr_we;
    logic              w_busy;
    logic              w_ext_we;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // State register and clear counter; rst always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + ADDR_W'(1);
            end
        end
    end

    // Next-state logic and the clear write strobe.
    always_comb begin
        w_next_state = r_state;
        w_clr_we     = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
                if (r_clr_idx == ADDR_W'(DEPTH - 1)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    // An external write is accepted only in RUN, and never into a protected entry 0.
    always_comb begin
        w_ext_we = wr && (r_state == ST_RUN);
        if ((ZERO_REG != 0) && (wa == '0)) begin
            w_ext_we = 1'b0;
        end
    end

    // Select the read data for each port: stored value, optional forwarding, then the zero rule.
    always_comb begin
        w_rd1 = r_mem[rs1];
        w_rd2 = r_mem[rs2];
`ifdef REGFILE_BYPASS_EN
        if (w_ext_we && (wa == rs1)) begin
            w_rd1 = wd;
        end
        if (w_ext_we && (wa == rs2)) begin
            w_rd2 = wd;
        end
`endif
        if ((ZERO_REG != 0) && (rs1 == '0)) begin
            w_rd1 = '0;
        end
        if ((ZERO_REG != 0) && (rs2 == '0)) begin
            w_rd2 = '0;
        end
    end

    // Storage update. rst itself leaves the contents alone; the clear sequence zeroes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_ext_we) begin
                r_mem[wa] <= wd;
            end
        end
    end

    // Registered read ports; held at zero during reset and clear.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_RUN)) begin
            r_read1 <= '0;
            r_read2 <= '0;
        end else begin
            r_read1 <= w_rd1;
            r_read2 <= w_rd2;
        end
    end

    assign read1 = r_read1;
    assign read2 = r_read2;
    assign busy  = w_busy;

endmodule
